maze_solve: RTL and testbench

- Command initiator that drives the navigate block.
- Runs a wall-follower algorithm: it issues a heading change or a forward-move command, waits for mv_cmplt, samples the lft_opn/rght_opn IR opening flags, and picks the next heading.
- Sits between the command/UART layer and navigate. It is the requester side of the strt_hdng/strt_mv → mv_cmplt handshake.

---
 rtl/maze_pkg.sv | 40 ++++
 rtl/maze_solve_turn_sel.sv | 22 ++
 rtl/maze_solve.sv | 121 ++++++++++++
 tb/tb_maze_solve.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types, heading encodings and the dir-to-heading lookup for the
// wall-following maze solver.
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MV,
    ST_WAIT_MV,
    ST_HDNG,
    ST_WAIT_HDNG,
    ST_DONE
  } state_t;

  typedef logic [1:0] dir_t;

  localparam logic [11:0] HDNG_N = 12'h000;
  localparam logic [11:0] HDNG_W = 12'h3FF;
  localparam logic [11:0] HDNG_S = 12'h7FF;
  localparam logic [11:0] HDNG_E = 12'hC00;

  // dir counts counter-clockwise from north, so a left turn is +1.
  function automatic logic [11:0] dir2hdng(input dir_t d);
    case (d)
      2'd0:    dir2hdng = HDNG_N;
      2'd1:    dir2hdng = HDNG_W;
      2'd2:    dir2hdng = HDNG_S;
      default: dir2hdng = HDNG_E;
    endcase
  endfunction

  function automatic dir_t hdng2dir(input logic [11:0] h);
    case (h)
      HDNG_W:  hdng2dir = 2'd1;
      HDNG_S:  hdng2dir = 2'd2;
      HDNG_E:  hdng2dir = 2'd3;
      default: hdng2dir = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/maze_solve_turn_sel.sv
// Next-heading choice for the wall follower: preferred side first, then the
// other side, otherwise turn around.
module turn_sel (
  input  logic [1:0] dir_i,
  input  logic       aff_i,
  input  logic       lft_opn_i,
  input  logic       rght_opn_i,
  output logic [1:0] nxt_dir_o
);

  always_comb begin
    nxt_dir_o = dir_i + 2'd2;
    if (aff_i) begin
      if (lft_opn_i)       nxt_dir_o = dir_i + 2'd1;
      else if (rght_opn_i) nxt_dir_o = dir_i - 2'd1;
    end else begin
      if (rght_opn_i)      nxt_dir_o = dir_i - 2'd1;
      else if (lft_opn_i)  nxt_dir_o = dir_i + 2'd1;
    end
  end

endmodule

// File: rtl/maze_solve.sv
// Wall-follower command initiator: alternates forward moves and heading
// changes toward navigate, stopping once the magnet has been found.
module maze_solve
  import maze_pkg::*;
#(
  parameter logic [11:0] INIT_HDNG = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        mv_cmplt,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        sol_cmplt,
  output logic        strt_hdng,
  output logic [11:0] dsrd_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic        solved,
  output logic [2:0]  state_dbg
);

  // Handshake: strt_hdng/strt_mv are single-cycle requests; navigate answers
  // each with a single-cycle mv_cmplt, which is only honoured in WAIT_* states.
  state_t      state_q;
  dir_t        dir_q;
  dir_t        dir_d;
  logic        aff_q;
  logic        sol_q;
  logic        strt_hdng_q;
  logic        strt_mv_q;
  logic        stp_lft_q;
  logic        stp_rght_q;
  logic        solved_q;
  logic [11:0] dsrd_hdng_q;

  turn_sel u_turn_sel (
    .dir_i      (dir_q),
    .aff_i      (aff_q),
    .lft_opn_i  (lft_opn),
    .rght_opn_i (rght_opn),
    .nxt_dir_o  (dir_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= hdng2dir(INIT_HDNG);
      aff_q       <= 1'b0;
      sol_q       <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      solved_q    <= 1'b0;
      dsrd_hdng_q <= INIT_HDNG;
    end else begin
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      if (state_q != ST_IDLE && sol_cmplt) sol_q <= 1'b1;
      // Abort: heading is kept so the next solve resumes facing the same way.
      if (!cmd_md) begin
        state_q    <= ST_IDLE;
        stp_lft_q  <= 1'b0;
        stp_rght_q <= 1'b0;
        sol_q      <= 1'b0;
        solved_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            aff_q      <= cmd0;
            stp_lft_q  <= cmd0;
            stp_rght_q <= ~cmd0;
            sol_q      <= 1'b0;
            strt_mv_q  <= 1'b1;
            state_q    <= ST_MV;
          end
          ST_MV:   state_q <= ST_WAIT_MV;
          ST_WAIT_MV: begin
            if (mv_cmplt) begin
              if (sol_cmplt || sol_q) begin
                solved_q <= 1'b1;
                state_q  <= ST_DONE;
              end else begin
                dir_q       <= dir_d;
                dsrd_hdng_q <= dir2hdng(dir_d);
                strt_hdng_q <= 1'b1;
                state_q     <= ST_HDNG;
              end
            end
          end
          ST_HDNG: state_q <= ST_WAIT_HDNG;
          ST_WAIT_HDNG: begin
            if (mv_cmplt) begin
              if (sol_q) begin
                solved_q <= 1'b1;
                state_q  <= ST_DONE;
              end else begin
                strt_mv_q <= 1'b1;
                state_q   <= ST_MV;
              end
            end
          end
          ST_DONE: state_q <= ST_DONE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign strt_hdng = strt_hdng_q;
  assign strt_mv   = strt_mv_q;
  assign stp_lft   = stp_lft_q;
  assign stp_rght  = stp_rght_q;
  assign solved    = solved_q;
  assign dsrd_hdng = dsrd_hdng_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_maze_solve.sv
// Randomized bench for maze_solve: a navigate stand-in answers each request,
// a heading model predicts every pulse and a monitor checks them in order.
module tb_maze_solve;
  import maze_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_md, cmd0, mv_cmplt, lft_opn, rght_opn, sol_cmplt;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, solved;
  logic [11:0] dsrd_hdng;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Event record: {kind, stp_lft, stp_rght, dsrd_hdng}; kind 1=mv, 2=hdng, 3=solved.
  logic [15:0] exp_q[$];
  int          m_dir;
  bit          m_aff;
  bit          solved_prev;

  maze_solve #(.INIT_HDNG(12'h000)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_md    (cmd_md),
    .cmd0      (cmd0),
    .mv_cmplt  (mv_cmplt),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .sol_cmplt (sol_cmplt),
    .strt_hdng (strt_hdng),
    .dsrd_hdng (dsrd_hdng),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .solved    (solved),
    .state_dbg (state_dbg)
  );

  always #10 clk = ~clk;

  function automatic logic [11:0] hd(input int d);
    case (d)
      0:       hd = 12'h000;
      1:       hd = 12'h3FF;
      2:       hd = 12'h7FF;
      default: hd = 12'hC00;
    endcase
  endfunction

  function automatic logic [15:0] ev(input logic [1:0] kind);
    ev = {kind, m_aff, ~m_aff, hd(m_dir)};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every visible request pulse or solved rising edge pops one prediction.
  always @(negedge clk) begin
    logic [1:0]  kind;
    logic [15:0] got;
    if (rst) begin
      solved_prev = 1'b0;
    end else begin
      kind = 2'd0;
      if (strt_mv || strt_hdng)
        check("pulse_exclusive", 16'(strt_mv & strt_hdng), 16'd0);
      if (strt_mv)                        kind = 2'd1;
      else if (strt_hdng)                 kind = 2'd2;
      else if (solved && !solved_prev)    kind = 2'd3;
      if (kind != 2'd0) begin
        got = {kind, stp_lft, stp_rght, dsrd_hdng};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got %h expected none at %0t", got, $time);
        end else begin
          check("event", got, exp_q.pop_front());
        end
      end
      solved_prev = solved;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_strt"}, 16'({strt_mv, strt_hdng}), 16'd0);
    check({nm, "_stp_solved"}, 16'({stp_lft, stp_rght, solved}), 16'd0);
    check({nm, "_hdng"}, 16'(dsrd_hdng), 16'h000);
    check({nm, "_state"}, 16'(state_dbg), 16'(ST_IDLE));
  endtask

  // First cycle is the request pulse itself; an mv_cmplt there must be ignored.
  task automatic gap();
    mv_cmplt = 1'($urandom_range(0, 1));
    lft_opn  = 1'($urandom_range(0, 1));
    rght_opn = 1'($urandom_range(0, 1));
    tick();
    mv_cmplt = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      lft_opn  = 1'($urandom_range(0, 1));
      rght_opn = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // mode: 0 random openings, 1 both open, 2 both closed.
  task automatic session(input bit aff, input int mode, input int steps,
                         input int sol_at, input bit abort_hd);
    bit l, r;
    cmd0  = aff;
    m_aff = aff;
    exp_q.push_back(ev(2'd1));
    cmd_md = 1'b1;
    tick();
    check("first_mv_latency", 16'(strt_mv), 16'd1);
    check("stp_flags", 16'({stp_lft, stp_rght}), 16'({aff, ~aff}));
    for (int s = 0; s < steps; s++) begin
      gap();
      l = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      r = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (s == sol_at) begin
        sol_cmplt = 1'b1;
        tick();
        sol_cmplt = 1'b0;
        tick();
        check("no_pulse_after_sol", 16'({strt_mv, strt_hdng}), 16'd0);
        exp_q.push_back(ev(2'd3));
        lft_opn = l; rght_opn = r; mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        check("solved_set", 16'({solved, strt_hdng, strt_mv}), 16'b100);
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        repeat (3) tick();
        check("done_quiet", 16'({solved, strt_hdng, strt_mv}), 16'b100);
        cmd_md = 1'b0;
        tick();
        check("solved_cleared", 16'({solved, stp_lft, stp_rght}), 16'd0);
        check("done_to_idle", 16'(state_dbg), 16'(ST_IDLE));
        return;
      end
      if (aff) m_dir = l ? (m_dir + 1) % 4 : r ? (m_dir + 3) % 4 : (m_dir + 2) % 4;
      else     m_dir = r ? (m_dir + 3) % 4 : l ? (m_dir + 1) % 4 : (m_dir + 2) % 4;
      exp_q.push_back(ev(2'd2));
      lft_opn = l; rght_opn = r; mv_cmplt = 1'b1;
      tick();
      mv_cmplt = 1'b0;
      check("hdng_latency", 16'(strt_hdng), 16'd1);
      check("hdng_value", 16'(dsrd_hdng), 16'(hd(m_dir)));
      gap();
      if (abort_hd && s == steps - 1) begin
        cmd_md = 1'b0;
        tick();
        check("abort_state", 16'(state_dbg), 16'(ST_IDLE));
        check("abort_stp", 16'({stp_lft, stp_rght}), 16'd0);
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        check("abort_no_pulse", 16'({strt_mv, strt_hdng}), 16'd0);
        repeat (2) tick();
        check("abort_hdng_kept", 16'(dsrd_hdng), 16'(hd(m_dir)));
        return;
      end
      exp_q.push_back(ev(2'd1));
      mv_cmplt = 1'b1;
      tick();
      mv_cmplt = 1'b0;
      check("mv_latency", 16'(strt_mv), 16'd1);
    end
    cmd_md = 1'b0;
    tick();
    check("end_idle", 16'({strt_mv, stp_lft, stp_rght}), 16'd0);
    tick();
  endtask

  initial begin
    int steps, sol_at;
    rst = 1'b1; cmd_md = 1'b0; cmd0 = 1'b0; mv_cmplt = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; sol_cmplt = 1'b0;
    m_dir = 0; m_aff = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    session(1'b1, 1, 4, -1, 1'b0);   // four left turns: wraps back to north
    session(1'b1, 2, 1, -1, 1'b0);   // dead end from north: reverse

    // Asynchronous reset in the middle of a move.
    cmd0 = 1'b0; m_aff = 1'b0;
    exp_q.push_back(ev(2'd1));
    cmd_md = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    m_dir = 0;
    cmd_md = 1'b0;
    #2;
    rst = 1'b0;
    tick();

    session(1'b0, 1, 1, -1, 1'b0);   // right affinity from north: east
    session(1'b1, 0, 3, 1, 1'b0);    // magnet found mid-move
    session(1'b0, 0, 2, -1, 1'b1);   // abort in WAIT_HDNG

    // sol_cmplt while idle must not latch.
    sol_cmplt = 1'b1;
    tick();
    sol_cmplt = 1'b0;
    session(1'b1, 0, 2, -1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      steps  = $urandom_range(1, 6);
      sol_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, steps - 1) : -1;
      session(1'($urandom_range(0, 1)), 0, steps, sol_at, ($urandom_range(0, 4) == 0));
    end

    repeat (4) tick();
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
